// File: rtl/unpool_if.sv
// Stream bundle for the unpool block: one input vector channel and one
// output beat channel, each with a valid/ready handshake.
interface unpool_if #(
    parameter int unsigned MAT_MUL_SIZE = 4,
    parameter int unsigned DWIDTH       = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data;

    // Unpool side: consumes vectors and produces beats.
    modport slave (
        input  in_valid,
        input  inp_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    // Environment side: produces vectors and consumes beats.
    modport master (
        output in_valid,
        output inp_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/unpool.sv
// Nearest-neighbour upsampler. Each accepted vector is buffered and emitted
// as K beats (K = 1, 2 or 4). With enable_unpool low the block is a straight
// combinational bypass.
// Build option: define UNPOOL_ZERO_FILL_EN to emit each buffered element once
// followed by K-1 zero elements instead of replicating it K times.
module unpool #(
    parameter int unsigned MAT_MUL_SIZE  = 4,
    parameter int unsigned DWIDTH        = 8,
    parameter int unsigned MAX_BITS_POOL = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable_unpool,
    input  logic [MAX_BITS_POOL-1:0] kernel_size,
    output logic                     done_unpool,
    unpool_if.slave                  bus
);

    localparam int unsigned IdxW = (MAT_MUL_SIZE > 1) ? $clog2(MAT_MUL_SIZE) : 1;

    typedef enum logic {StIdle, StEmit} state_t;

    state_t            state_q;
    logic [DWIDTH-1:0] vec_q [MAT_MUL_SIZE];
    logic [1:0]        b_q;      // beat index within the current vector
    logic [1:0]        k_log_q;  // log2 of the captured upsample factor

    logic [1:0]                     k_log_in;
    logic [1:0]                     last_b;
    logic                           last_beat;
    logic                           in_ready_en;
    logic                           load;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] beat_data;

    // Map kernel_size to log2(K); anything other than 2 or 4 behaves as K=1.
    always_comb begin
        k_log_in = 2'd0;
        if (32'(kernel_size) == 32'd2) begin
            k_log_in = 2'd1;
        end else if (32'(kernel_size) == 32'd4) begin
            k_log_in = 2'd2;
        end
    end

    // Index of the final beat for the captured K.
    always_comb begin
        unique case (k_log_q)
            2'd0:    last_b = 2'd0;
            2'd1:    last_b = 2'd1;
            default: last_b = 2'd3;
        endcase
    end

    assign last_beat = (b_q == last_b);

    // A new vector may enter from IDLE, or on the final beat transfer so
    // back-to-back vectors stream with no bubble.
    assign in_ready_en = (state_q == StIdle) || (last_beat && bus.out_ready);
    assign load        = bus.in_valid && in_ready_en;

    // Control FSM plus vector buffer; bypass mode pins the FSM in IDLE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            b_q     <= 2'd0;
            k_log_q <= 2'd0;
            for (int i = 0; i < int'(MAT_MUL_SIZE); i++) begin
                vec_q[i] <= '0;
            end
        end else if (!enable_unpool) begin
            state_q <= StIdle;
        end else if (load) begin
            state_q <= StEmit;
            b_q     <= 2'd0;
            k_log_q <= k_log_in;
            for (int i = 0; i < int'(MAT_MUL_SIZE); i++) begin
                vec_q[i] <= bus.inp_data[i*DWIDTH +: DWIDTH];
            end
        end else if (state_q == StEmit && bus.out_ready) begin
            if (last_beat) begin
                state_q <= StIdle;
            end else begin
                b_q <= b_q + 2'd1;
            end
        end
    end

    // Build the current beat purely from registered state: stream position
    // n = b*MAT_MUL_SIZE + j maps to buffer element n/K.
    always_comb begin
        int unsigned pos;
        int unsigned src;
        pos       = 0;
        src       = 0;
        beat_data = '0;
        for (int unsigned j = 0; j < MAT_MUL_SIZE; j++) begin
            pos = 32'(b_q) * MAT_MUL_SIZE + j;
            src = pos >> k_log_q;
`ifdef UNPOOL_ZERO_FILL_EN
            // Only the first position of each K-wide group carries data.
            if ((pos & ((32'd1 << k_log_q) - 32'd1)) == 32'd0) begin
                beat_data[j*DWIDTH +: DWIDTH] = vec_q[IdxW'(src)];
            end
`else
            beat_data[j*DWIDTH +: DWIDTH] = vec_q[IdxW'(src)];
`endif
        end
    end

    // Output steering: bypass is fully combinational, otherwise the FSM owns
    // the handshake.
    always_comb begin
        if (!enable_unpool) begin
            bus.out_data  = bus.inp_data;
            bus.out_valid = bus.in_valid;
            bus.in_ready  = bus.out_ready;
            done_unpool   = 1'b1;
        end else begin
            bus.out_data  = beat_data;
            bus.out_valid = (state_q == StEmit);
            bus.in_ready  = in_ready_en;
            done_unpool   = (state_q == StEmit) && last_beat && bus.out_ready;
        end
    end

endmodule

// File: doc/unpool.md
UNPOOL -- requirements
Module: unpool

Interface
REQ-001 SHALL have parameter MAT_MUL_SIZE, default 4, number of elements per vector.
REQ-002 SHALL have parameter DWIDTH, default 8, bits per element.
REQ-003 SHALL have parameter MAX_BITS_POOL, default 3, width of kernel_size.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 enable_unpool  input  1  1 = upsample, 0 = bypass.
REQ-007 kernel_size  input  MAX_BITS_POOL  upsample factor; legal values 1, 2, 4.
REQ-008 in_valid  input  1  inp_data holds a vector.
REQ-009 in_ready  output  1  unpool accepts a vector this cycle.
REQ-010 inp_data  input  MAT_MUL_SIZE*DWIDTH  input vector; element 0 in the LSBs.
REQ-011 out_valid  output  1  out_data holds a beat.
REQ-012 out_ready  input  1  downstream accepts a beat this cycle.
REQ-013 out_data  output  MAT_MUL_SIZE*DWIDTH  output beat; element 0 in the LSBs.
REQ-014 done_unpool  output  1  one-cycle pulse on the final beat of a vector.

Function
REQ-015 Transfers SHALL occur only on a cycle where valid and ready are both 1.
REQ-016 With enable_unpool=0, connections SHALL be combinational:
- out_data=inp_data
- out_valid=in_valid
- in_ready=out_ready
- done_unpool=1
- internal state held in IDLE.
REQ-017 SHALL have two states, IDLE and EMIT.
REQ-018 IDLE: in_ready=1 and out_valid=0.
REQ-019 An input transfer in IDLE SHALL, on the next edge:
- capture inp_data into a vector buffer;
- capture kernel_size as K;
- clear the beat counter b;
- enter EMIT.
REQ-020 kernel_size values other than 1, 2, 4 SHALL be captured as K=1.
REQ-021 EMIT: out_valid=1; out_data SHALL be driven from registers only (no combinational path from inp_data).
REQ-022 Each input vector SHALL produce exactly K output beats, b=0..K-1, in order.
REQ-023 Beat b, output element j SHALL equal buffer element floor((b*MAT_MUL_SIZE+j)/K) (nearest-neighbour replication).
REQ-024 While out_ready=0 in EMIT, out_data, b and the buffer SHALL hold.
REQ-025 A non-final beat transfer SHALL increment b.
REQ-026 done_unpool SHALL be 1 exactly in the cycle where beat b=K-1 transfers.
REQ-027 In EMIT, in_ready SHALL be 1 only when b=K-1 and out_ready=1.
REQ-028 On the final beat transfer:
- with a simultaneous input transfer, load the new vector, clear b and stay in EMIT (zero bubble);
- otherwise return to IDLE.
REQ-029 kernel_size changes while in EMIT SHALL have no effect until the next input capture.
REQ-030 Deasserting enable_unpool mid-vector SHALL:
- abandon the remaining beats;
- force IDLE on the next edge;
- keep outputs in bypass.
REQ-031 Sustained throughput SHALL be one output beat per cycle while out_ready=1.

Reset
REQ-032 When resetn=0 at a rising edge, the block SHALL enter IDLE with buffer=0, b=0 and K=1.
REQ-033 Reset SHALL override any transfer on the same edge; a vector mid-emission is discarded.
REQ-034 After reset with enable_unpool=1: in_ready=1, out_valid=0, out_data=0, done_unpool=0.

Configuration
REQ-035 Macro UNPOOL_ZERO_FILL_EN SHALL select zero-fill mode when defined:
- output stream position n SHALL carry buffer element n/K when n mod K=0;
- every other position SHALL be 0.
REQ-036 Without UNPOOL_ZERO_FILL_EN, replication per REQ-023 SHALL apply; handshake and timing SHALL be identical in both builds.

Verification (MAT_MUL_SIZE=4, DWIDTH=8, elements listed 0..3)
REQ-037 K=2, input 11,22,33,44, out_ready=1 -> beat0 11,11,22,22; beat1 33,33,44,44; done_unpool high on beat1 only.
REQ-038 K=4, input 11,22,33,44, out_ready toggling 1,0 -> four beats 11x4, 22x4, 33x4, 44x4; each beat held stable while out_ready=0.
REQ-039 K=2, back-to-back vectors A=01,02,03,04 and B=05,06,07,08, in_valid=1 throughout -> four consecutive beats with no idle cycle; in_ready high only on the final-beat cycles.
REQ-040 kernel_size=3, input 0A,0B,0C,0D -> single beat 0A,0B,0C,0D; done_unpool=1.
REQ-041 K=4, resetn=0 asserted after beat1 -> next cycle out_valid=0, in_ready=1, out_data=0; no further beats of that vector.
REQ-042 UNPOOL_ZERO_FILL_EN defined, K=2, input 11,22,33,44 -> beat0 11,00,22,00; beat1 33,00,44,00.
